// File: rtl/wb_queue.sv
// wb_queue: writeback buffer in front of the 32x32 register file.
// Accepts results from the load unit (mem_*) and the ALU (alu_*), up to both in the
// same cycle. Loads are ordered before same-cycle ALU results. The buffer drains one
// entry per cycle into the register file's single write port (rf_load/rf_dest/rf_in).
// Writes to x0 are accepted and discarded without taking a slot.
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   mem_valid/dest/data  load result in, mem_ready out
//   alu_valid/dest/data  ALU result in, alu_ready out
//   rf_load/dest/in      register file write port (decoded from state only)
//   src_a/src_b          forwarding lookup indices
//   fwd_*_hit/fwd_*_data youngest pending write to the looked-up register
//   count                entries currently held
// Optional: define WB_QUEUE_STATS_EN to add stall_cycles[31:0], a saturating count of
// cycles in which a valid producer was refused.
module wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [4:0]       mem_dest,
  input  logic [31:0]      mem_data,
  output logic             mem_ready,
  input  logic             alu_valid,
  input  logic [4:0]       alu_dest,
  input  logic [31:0]      alu_data,
  output logic             alu_ready,
  output logic             rf_load,
  output logic [4:0]       rf_dest,
  output logic [31:0]      rf_in,
  input  logic [4:0]       src_a,
  input  logic [4:0]       src_b,
  output logic             fwd_a_hit,
  output logic [31:0]      fwd_a_data,
  output logic             fwd_b_hit,
  output logic [31:0]      fwd_b_data,
  output logic [PTR_W:0]   count
`ifdef WB_QUEUE_STATS_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam logic [PTR_W+1:0] DepthW = DEPTH[PTR_W+1:0];

  logic [4:0]       dest_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q, tail_p1, alu_slot;
  logic [PTR_W:0]   count_q;

  logic             mem_nz, alu_nz, has_room, mem_claims, alu_room;
  logic             mem_take, alu_take, drain;
  logic [PTR_W+1:0] alu_need;

  assign mem_nz   = mem_dest != 5'd0;
  assign alu_nz   = alu_dest != 5'd0;
  // Room is judged on the registered count only; the entry draining this cycle
  // frees its slot from the next cycle on.
  assign has_room = {1'b0, count_q} < DepthW;
  // A load that will occupy a slot this cycle reserves it ahead of the ALU result.
  assign mem_claims = mem_valid && mem_nz && has_room;
  assign alu_need   = {1'b0, count_q} + {{(PTR_W + 1){1'b0}}, mem_claims}
                      + {{(PTR_W + 1){1'b0}}, 1'b1};
  assign alu_room   = alu_need <= DepthW;

  assign mem_ready = !mem_nz || has_room;
  assign alu_ready = !alu_nz || alu_room;

  assign mem_take = rst && mem_claims;
  assign alu_take = rst && alu_valid && alu_nz && alu_room;
  assign drain    = count_q != '0;

  assign tail_p1  = tail_q + {{(PTR_W - 1){1'b0}}, 1'b1};
  assign alu_slot = mem_take ? tail_p1 : tail_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (mem_take) begin
        dest_q[tail_q] <= mem_dest;
        data_q[tail_q] <= mem_data;
      end
      if (alu_take) begin
        dest_q[alu_slot] <= alu_dest;
        data_q[alu_slot] <= alu_data;
      end
      head_q  <= head_q + PTR_W'(drain);
      tail_q  <= tail_q + PTR_W'(mem_take) + PTR_W'(alu_take);
      count_q <= count_q + (PTR_W + 1)'(mem_take) + (PTR_W + 1)'(alu_take)
                 - (PTR_W + 1)'(drain);
    end
  end

  // Write port is a pure function of state; stale slot contents are masked when empty.
  always_comb begin
    rf_load = drain;
    rf_dest = '0;
    rf_in   = '0;
    if (drain) begin
      rf_dest = dest_q[head_q];
      rf_in   = data_q[head_q];
    end
  end

  // Walk entries oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             live;
    fwd_a_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_hit  = 1'b0;
    fwd_b_data = '0;
    idx        = '0;
    live       = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx  = head_q + PTR_W'(i);
      live = (PTR_W + 1)'(i) < count_q;
      if (live && src_a != 5'd0 && dest_q[idx] == src_a) begin
        fwd_a_hit  = 1'b1;
        fwd_a_data = data_q[idx];
      end
      if (live && src_b != 5'd0 && dest_q[idx] == src_b) begin
        fwd_b_hit  = 1'b1;
        fwd_b_data = data_q[idx];
      end
    end
  end

  assign count = count_q;

`ifdef WB_QUEUE_STATS_EN
  logic [31:0] stall_q;
  logic        stall;

  assign stall = (mem_valid && !mem_ready) || (alu_valid && !alu_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (stall && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             mem_valid = 1'b0;
  logic [4:0]       mem_dest = '0;
  logic [31:0]      mem_data = '0;
  logic             mem_ready;
  logic             alu_valid = 1'b0;
  logic [4:0]       alu_dest = '0;
  logic [31:0]      alu_data = '0;
  logic             alu_ready;
  logic             rf_load;
  logic [4:0]       rf_dest;
  logic [31:0]      rf_in;
  logic [4:0]       src_a = '0;
  logic [4:0]       src_b = '0;
  logic             fwd_a_hit, fwd_b_hit;
  logic [31:0]      fwd_a_data, fwd_b_data;
  logic [PTR_W:0]   count;
`ifdef WB_QUEUE_STATS_EN
  logic [31:0]      stall_cycles;
`endif

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in),
    .src_a(src_a), .src_b(src_b),
    .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
    .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
    .count(count)
`ifdef WB_QUEUE_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t        pend[$];  // reference FIFO: results accepted and not yet written
  ent_t        sbq[$];   // scoreboard of register-file writes still to be observed
  int          checks = 0;
  int          failures = 0;
  bit          armed = 1'b0;
  logic [31:0] stall_m = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every register-file write must be the oldest outstanding accepted result.
  always @(negedge clk) begin
    ent_t e;
    if (armed && rst && rf_load) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rf_unexpected: got write %0d/%0h expected none", rf_dest, rf_in);
      end else begin
        e = sbq.pop_front();
        chk("rf_dest", 64'(rf_dest), 64'(e.dest));
        chk("rf_in", 64'(rf_in), 64'(e.data));
      end
    end
  end

  task automatic step(input bit r, input bit mv, input logic [4:0] md, input logic [31:0] mdat,
                      input bit av, input logic [4:0] ad, input logic [31:0] adat,
                      input logic [4:0] sa, input logic [4:0] sb);
    int          free;
    bit          emr, ear, em, ea, hit_a, hit_b;
    logic [31:0] da, db;
    rst = r;
    mem_valid = mv; mem_dest = md; mem_data = mdat;
    alu_valid = av; alu_dest = ad; alu_data = adat;
    src_a = sa; src_b = sb;
    @(negedge clk);
    free = DEPTH - pend.size();
    emr  = (md == 0) || (free >= 1);
    em   = mv && md != 0 && free >= 1;
    ear  = (ad == 0) || (free >= 1 + int'(em));
    ea   = av && ad != 0 && ear;
    chk("mem_ready", 64'(mem_ready), 64'(emr));
    chk("alu_ready", 64'(alu_ready), 64'(ear));
    chk("count", 64'(count), 64'(pend.size()));
    chk("rf_load", 64'(rf_load), 64'(pend.size() > 0));
    if (pend.size() == 0) begin
      chk("rf_dest_idle", 64'(rf_dest), 64'd0);
      chk("rf_in_idle", 64'(rf_in), 64'd0);
    end
    hit_a = 1'b0; da = '0; hit_b = 1'b0; db = '0;
    foreach (pend[i]) begin
      if (sa != 0 && pend[i].dest == sa) begin hit_a = 1'b1; da = pend[i].data; end
      if (sb != 0 && pend[i].dest == sb) begin hit_b = 1'b1; db = pend[i].data; end
    end
    chk("fwd_a_hit", 64'(fwd_a_hit), 64'(hit_a));
    chk("fwd_a_data", 64'(fwd_a_data), 64'(da));
    chk("fwd_b_hit", 64'(fwd_b_hit), 64'(hit_b));
    chk("fwd_b_data", 64'(fwd_b_data), 64'(db));
`ifdef WB_QUEUE_STATS_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(stall_m));
    if (!r) stall_m = '0;
    else if (((mv && !emr) || (av && !ear)) && stall_m != 32'hFFFF_FFFF) stall_m++;
`endif
    @(posedge clk);
    if (!r) begin
      pend.delete();
      sbq.delete();
    end else begin
      if (pend.size() > 0) void'(pend.pop_front());
      if (em) begin pend.push_back({md, mdat}); sbq.push_back({md, mdat}); end
      if (ea) begin pend.push_back({ad, adat}); sbq.push_back({ad, adat}); end
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] sa, input logic [4:0] sb);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, sa, sb);
  endtask

  initial begin
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    armed = 1'b1;

    // Reset state, then single ALU write with its two-cycle drain.
    idle(5'd5, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
    idle(5'd5, 5'd0);
    idle(5'd5, 5'd0);

    // Dual enqueue to the same register: load is older, ALU result is youngest.
    step(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 5'd3);
    idle(5'd3, 5'd3);
    idle(5'd3, 5'd0);
    idle(5'd3, 5'd0);

    // Backpressure: fill to three, then load takes the last slot and ALU is refused.
    step(1'b1, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 5'd1, 5'd2);
    step(1'b1, 1'b1, 5'd4, 32'hA3, 1'b1, 5'd6, 32'hA4, 5'd4, 5'd6);
    step(1'b1, 1'b1, 5'd7, 32'hA5, 1'b1, 5'd8, 32'hA6, 5'd7, 5'd8);
    step(1'b1, 1'b1, 5'd9, 32'hA7, 1'b1, 5'd0, 32'hA8, 5'd9, 5'd6);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd9);
    for (int i = 0; i < 5; i++) idle(5'd9, 5'd7);

    // Reset with three entries pending; none of them may reach the register file.
    step(1'b1, 1'b1, 5'd10, 32'hB1, 1'b1, 5'd11, 32'hB2, 5'd10, 5'd11);
    step(1'b1, 1'b1, 5'd12, 32'hB3, 1'b1, 5'd13, 32'hB4, 5'd12, 5'd13);
    step(1'b0, 1'b1, 5'd14, 32'hB5, 1'b1, 5'd15, 32'hB6, 5'd12, 5'd13);
    idle(5'd12, 5'd13);
    idle(5'd10, 5'd11);

    // Randomized mixed traffic with small register range for frequent hits and x0s.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) != 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 2 * DEPTH; i++) idle(5'd1, 5'd2);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
